loop_sequencer: RTL and testbench

LOOP_SEQUENCER -- requirements
Module: loop_sequencer

---
 rtl/loop_sequencer.sv | 93 +++++++++
 tb/tb_loop_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/loop_sequencer.sv
// loop_sequencer: periodic angle/rate/mixer stage sequencer; define SEQ_WATCHDOG_EN to build the stage timeout and sticky FAULT
module loop_sequencer #(
  parameter int LOOP_PERIOD_US = 1000,
  parameter int STAGE_TIMEOUT_US = 200
) (
  input  logic        us_clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        angle_complete,
  input  logic        rate_complete,
  input  logic        mixer_complete,
  output logic        start_angle,
  output logic        start_rate,
  output logic        start_mixer,
  output logic        loop_done,
  output logic        busy,
  output logic        fault,
  output logic [1:0]  fault_stage,
  output logic [7:0]  overrun_count,
  output logic [15:0] loop_count
);
  typedef enum logic [3:0] {
    IDLE, START_ANGLE, WAIT_ANGLE, START_RATE, WAIT_RATE, START_MIX, WAIT_MIX, DONE, FAULT
  } state_t;
  state_t state, next_state;
  logic [15:0] period_cnt;
  logic tick, timeout;
  assign tick = enable && period_cnt == 16'(LOOP_PERIOD_US - 1);
  // Period counter free-runs while enabled and is parked at 0 otherwise
  always_ff @(posedge us_clk or negedge resetn)
    if (!resetn) period_cnt <= '0;
    else period_cnt <= (!enable || tick) ? '0 : period_cnt + 16'd1;
`ifdef SEQ_WATCHDOG_EN
  logic [15:0] stage_timer;
  logic in_wait;
  assign in_wait = state inside {WAIT_ANGLE, WAIT_RATE, WAIT_MIX};
  assign timeout = in_wait && stage_timer == 16'(STAGE_TIMEOUT_US - 1);
  assign fault = state == FAULT;
  // Stage timer is zero outside WAIT states, so every WAIT starts counting from 0
  always_ff @(posedge us_clk or negedge resetn)
    if (!resetn) stage_timer <= '0;
    else stage_timer <= in_wait ? stage_timer + 16'd1 : '0;
  // Faulting stage is latched on entry to FAULT and cleared when enable drops
  always_ff @(posedge us_clk or negedge resetn)
    if (!resetn) fault_stage <= 2'd0;
    else if (!enable) fault_stage <= 2'd0;
    else if (state != FAULT && next_state == FAULT)
      fault_stage <= state == WAIT_ANGLE ? 2'd1 : state == WAIT_RATE ? 2'd2 : 2'd3;
`else
  assign timeout = 1'b0;
  assign fault = 1'b0;
  assign fault_stage = 2'd0;
`endif
  // State register
  always_ff @(posedge us_clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= next_state;
  // Next state: enable low always wins; a complete beats a same-cycle timeout
  always_comb begin
    next_state = state;
    if (!enable) next_state = IDLE;
    else
      case (state)
        IDLE:        next_state = tick ? START_ANGLE : IDLE;
        START_ANGLE: next_state = WAIT_ANGLE;
        WAIT_ANGLE:  next_state = angle_complete ? START_RATE : timeout ? FAULT : WAIT_ANGLE;
        START_RATE:  next_state = WAIT_RATE;
        WAIT_RATE:   next_state = rate_complete ? START_MIX : timeout ? FAULT : WAIT_RATE;
        START_MIX:   next_state = WAIT_MIX;
        WAIT_MIX:    next_state = mixer_complete ? DONE : timeout ? FAULT : WAIT_MIX;
        DONE:        next_state = IDLE;
        FAULT:       next_state = FAULT;
        default:     next_state = IDLE;
      endcase
  end
  // Outputs decoded straight from the state register
  always_comb begin
    start_angle = state == START_ANGLE;
    start_rate  = state == START_RATE;
    start_mixer = state == START_MIX;
    loop_done   = state == DONE;
    busy        = state != IDLE && state != FAULT;
  end
  // Ticks landing on a running loop are dropped and counted; completed loops are counted
  always_ff @(posedge us_clk or negedge resetn)
    if (!resetn) begin
      overrun_count <= '0;
      loop_count    <= '0;
    end else begin
      if (tick && busy && overrun_count != 8'hFF) overrun_count <= overrun_count + 8'd1;
      if (state == DONE) loop_count <= loop_count + 16'd1;
    end
endmodule

// File: tb/tb_loop_sequencer.sv
// tb_loop_sequencer: scoreboard bench with a tick/latency arithmetic reference model
module tb_loop_sequencer;
  localparam int P = 100;
  localparam int TO = 20;
  logic us_clk = 0, resetn = 0, enable = 0;
  logic angle_complete = 0, rate_complete = 0, mixer_complete = 0;
  logic start_angle, start_rate, start_mixer, loop_done, busy, fault;
  logic [1:0] fault_stage;
  logic [7:0] overrun_count;
  logic [15:0] loop_count;

  loop_sequencer #(.LOOP_PERIOD_US(P), .STAGE_TIMEOUT_US(TO)) dut (
    .us_clk(us_clk), .resetn(resetn), .enable(enable),
    .angle_complete(angle_complete), .rate_complete(rate_complete), .mixer_complete(mixer_complete),
    .start_angle(start_angle), .start_rate(start_rate), .start_mixer(start_mixer),
    .loop_done(loop_done), .busy(busy), .fault(fault), .fault_stage(fault_stage),
    .overrun_count(overrun_count), .loop_count(loop_count)
  );

  always #5 us_clk = ~us_clk;
  int cyc = 0;
  always @(posedge us_clk) cyc <= cyc + 1;

  typedef struct {int kind; int at;} ev_t;
  ev_t exp_q[$];
  ev_t e;
  string names[4] = '{"start_angle", "start_rate", "start_mixer", "loop_done"};
  int passed = 0, total = 0;
  int da_a[16], dr_a[16], dm_a[16];
  int li = 0, due_a = -1, due_r = -1, due_m = -1;
  int exp_ovr = 0, exp_loops = 0;
  logic [3:0] p;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic void push(input int k, input int at);
    ev_t x;
    x.kind = k;
    x.at = at;
    exp_q.push_back(x);
  endfunction

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge us_clk);
  endtask

  task automatic drain(input int budget);
    int t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      @(negedge us_clk);
      t++;
    end
    chk("pending_pulses", exp_q.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_start_angle"}, int'(start_angle), 0);
    chk({tag, "_start_rate"}, int'(start_rate), 0);
    chk({tag, "_start_mixer"}, int'(start_mixer), 0);
    chk({tag, "_loop_done"}, int'(loop_done), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_fault"}, int'(fault), 0);
    chk({tag, "_fault_stage"}, int'(fault_stage), 0);
    chk({tag, "_overrun_count"}, int'(overrun_count), 0);
    chk({tag, "_loop_count"}, int'(loop_count), 0);
  endtask

  // Reference model: ticks every P cycles from enable; a loop takes the first tick after the
  // previous loop's DONE; ticks in (tick, done] are overruns.
  task automatic run_loops(input int n, output int last_done);
    int tb0, prev, t, sa, sr, sm, d, j;
    tb0 = cyc + P - 1;
    prev = -1;
    for (int i = 0; i < n; i++) begin
      j = li + i;
      t = prev < tb0 ? tb0 : tb0 + ((prev - tb0) / P + 1) * P;
      sa = t + 1;
      sr = sa + da_a[j] + 1;
      sm = sr + dr_a[j] + 1;
      d = sm + dm_a[j] + 1;
      push(0, sa); push(1, sr); push(2, sm); push(3, d);
      exp_ovr = (exp_ovr + (d - t) / P > 255) ? 255 : exp_ovr + (d - t) / P;
      exp_loops++;
      prev = d;
    end
    last_done = prev;
    enable = 1;
  endtask

  // Stage responder: returns each complete a per-loop delay after its start pulse
  initial forever begin
    @(negedge us_clk);
    angle_complete = cyc == due_a;
    rate_complete = cyc == due_r;
    mixer_complete = cyc == due_m;
    if (start_angle) begin
      due_a = da_a[li] < 0 ? -1 : cyc + da_a[li];
      li++;
    end
    if (start_rate) due_r = dr_a[li-1] < 0 ? -1 : cyc + dr_a[li-1];
    if (start_mixer) due_m = dm_a[li-1] < 0 ? -1 : cyc + dm_a[li-1];
  end

  // Monitor: every pulse must match the head of the expected queue in kind and cycle
  initial forever begin
    @(negedge us_clk);
    p = {loop_done, start_mixer, start_rate, start_angle};
    if (resetn)
      for (int k = 0; k < 4; k++)
        if (p[k]) begin
          total++;
          if (exp_q.size() == 0) $display("FAIL unexpected_pulse: got %s at cycle %0d, none expected", names[k], cyc);
          else begin
            e = exp_q.pop_front();
            if (e.kind == k && e.at == cyc) passed++;
            else $display("FAIL pulse: got %s at cycle %0d, expected %s at cycle %0d", names[k], cyc, names[e.kind], e.at);
          end
        end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int last, c, t, sa, sr, sm, ovr_snap;
    repeat (3) @(negedge us_clk);
    check_zero("reset");
    resetn = 1;
    repeat (2) @(negedge us_clk);
    chk("idle_busy", int'(busy), 0);

    for (int i = 0; i < 6; i++) begin
`ifdef SEQ_WATCHDOG_EN
      da_a[i] = $urandom_range(1, TO); dr_a[i] = $urandom_range(1, TO); dm_a[i] = $urandom_range(1, TO);
`else
      da_a[i] = $urandom_range(1, 30); dr_a[i] = $urandom_range(1, 30); dm_a[i] = $urandom_range(1, 30);
`endif
    end
    da_a[0] = 1; dr_a[0] = 1; dm_a[0] = 1;
`ifdef SEQ_WATCHDOG_EN
    da_a[3] = TO;
`else
    da_a[2] = 1; dr_a[2] = 150; dm_a[2] = 1;
`endif
    run_loops(6, last);
    wait_until(last + 1);
    enable = 0;
    drain(50);
    chk("loop_count_after_run", int'(loop_count), exp_loops);
    chk("overrun_after_run", int'(overrun_count), exp_ovr);
    chk("fault_after_run", int'(fault), 0);
    @(negedge us_clk);
    chk("busy_after_run", int'(busy), 0);

    da_a[6] = 1; dr_a[6] = 10; dm_a[6] = 1;
    c = cyc;
    t = c + P - 1;
    sa = t + 1;
    sr = sa + 2;
    push(0, sa); push(1, sr);
    enable = 1;
    wait_until(sr + 3);
    enable = 0;
    @(negedge us_clk);
    chk("drop_busy", int'(busy), 0);
    wait_until(sr + 15);
    chk("drop_loop_count", int'(loop_count), exp_loops);
    drain(10);

`ifdef SEQ_WATCHDOG_EN
    da_a[7] = 1; dr_a[7] = 1; dm_a[7] = -1;
    c = cyc;
    t = c + P - 1;
    sa = t + 1; sr = sa + 2; sm = sr + 2;
    push(0, sa); push(1, sr); push(2, sm);
    ovr_snap = int'(overrun_count);
    enable = 1;
    wait_until(sm + 20);
    chk("fault_before_timeout", int'(fault), 0);
    @(negedge us_clk);
    chk("fault_set", int'(fault), 1);
    chk("fault_stage_mixer", int'(fault_stage), 3);
    chk("fault_busy", int'(busy), 0);
    wait_until(t + P + 3);
    chk("fault_tick_ignored", int'(overrun_count), ovr_snap);
    chk("fault_sticky", int'(fault), 1);
    enable = 0;
    @(negedge us_clk);
    chk("fault_cleared", int'(fault), 0);
    chk("fault_stage_cleared", int'(fault_stage), 0);
    drain(10);
`else
    da_a[7] = 1; dr_a[7] = 300 * P; dm_a[7] = 1;
    run_loops(1, last);
    wait_until(last + 1);
    enable = 0;
    drain(50);
    chk("overrun_saturated", int'(overrun_count), exp_ovr);
    chk("overrun_is_255", int'(overrun_count), 255);
    chk("loop_count_after_sat", int'(loop_count), exp_loops);
`endif

    @(negedge us_clk);
    da_a[8] = 1; dr_a[8] = 5; dm_a[8] = 1;
    c = cyc;
    t = c + P - 1;
    push(0, t + 1); push(1, t + 3);
    enable = 1;
    wait_until(t + 5);
    resetn = 0;
    #1;
    check_zero("midloop_reset");
    enable = 0;
    exp_q.delete();
    repeat (3) @(negedge us_clk);
    resetn = 1;
    repeat (15) @(negedge us_clk);
    check_zero("after_reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
